// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pkg
//  Purpose  : Shared constants and pixel-format helper for cam_stream_packer.
//  Revision : 1.0  initial release
// ============================================================================
package cam_pkg;

  // Output word formats
  localparam int PACK_RGB888 = 0;  // one RGB565 pixel expanded to {R8,G8,B8,8'h00}
  localparam int PACK_2PIX   = 1;  // two raw 16-bit pixels per 32-bit word

  // Default width of the pixel and line statistics counters
  localparam int CNT_W_DEFAULT = 12;

  // Expand RGB565 to RGB888 by replicating each channel's LSB into the new low bits
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], {3{d[11]}}, d[10:5], {2{d[5]}}, d[4:0], {3{d[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : cam_sync_delay
//  Purpose  : Generic DLY-deep, W-wide shift register with async reset.
//             Stage k is s[k]; the MSB of stage 1 is exposed as a sync tap.
//  Revision : 1.0  initial release
// ============================================================================
module cam_sync_delay #(
  parameter int DLY = 2,
  parameter int W   = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         head_msb
);

  logic [W-1:0] s [1:DLY];

  // Shift the bus one stage per clock; every stage clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DLY; k++) s[k] <= '0;
    end else begin
      s[1] <= din;
      for (int k = 2; k <= DLY; k++) s[k] <= s[k-1];
    end
  end

  assign dout     = s[DLY];
  assign head_msb = s[1][W-1];

endmodule
`default_nettype wire

// File: rtl/cam_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : cam_stream_packer
//  Purpose  : Delays the CMOS capture stream by DLY stages, formats pixels
//             into 32-bit write words (RGB888 expansion or two-pixel packing),
//             raises a frame-start request with req/ack handshake and keeps
//             per-line / per-frame statistics.
//  Options  : CAM_TEST_PATTERN_EN adds test_en, which swaps in_data for a
//             counter-derived test pattern ahead of the delay line.
//  Revision : 1.0  initial release
// ============================================================================
module cam_stream_packer
  import cam_pkg::*;
#(
  parameter int DLY       = 2,
  parameter int PACK_MODE = PACK_RGB888,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vsync,
  input  logic             in_href,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
`ifdef CAM_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  output logic             out_en,
  output logic [31:0]      out_data,
  output logic             frame_req,
  input  logic             frame_req_ack,
  output logic [CNT_W-1:0] last_line_pix,
  output logic [CNT_W-1:0] last_frame_lines,
  output logic             frame_overrun
);

  localparam int              BUS_W   = 19;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [15:0]      pix_src;
  logic [BUS_W-1:0] dly_out;
  logic             in_vsync_q;
  logic             d_href, d_valid;
  logic [15:0]      d_data;
  logic             href_q, href_fall, pix_line, fs;
  logic [CNT_W-1:0] pix_cnt, line_cnt, line_next;

`ifdef CAM_TEST_PATTERN_EN
  // Counters on the undelayed stream, used only to build the test pattern
  logic [CNT_W-1:0] pix_cnt_raw, line_cnt_raw;
  logic             href_raw_q, raw_fall;

  assign raw_fall = href_raw_q & ~in_href;

  // Raw pixel/line counting mirrors the delayed statistics but ahead of stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_raw_q   <= 1'b0;
      pix_cnt_raw  <= '0;
      line_cnt_raw <= '0;
    end else begin
      href_raw_q <= in_href;
      if (raw_fall) pix_cnt_raw <= '0;
      else if (in_valid && in_href && pix_cnt_raw != CNT_MAX)
        pix_cnt_raw <= pix_cnt_raw + CNT_W'(1);
      if (fs) line_cnt_raw <= '0;
      else if (raw_fall && line_cnt_raw != CNT_MAX)
        line_cnt_raw <= line_cnt_raw + CNT_W'(1);
    end
  end

  assign pix_src = test_en ? {pix_cnt_raw[4:0], line_cnt_raw[5:0], pix_cnt_raw[9:5]}
                           : in_data;
`else
  assign pix_src = in_data;
`endif

  cam_sync_delay #(
    .DLY (DLY),
    .W   (BUS_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      ({in_vsync, in_href, in_valid, pix_src}),
    .dout     (dly_out),
    .head_msb (in_vsync_q)
  );

  assign d_href  = dly_out[17];
  assign d_valid = dly_out[16];
  assign d_data  = dly_out[15:0];

  // Frame start is the vsync falling edge, seen against the raw input
  assign fs        = in_vsync_q & ~in_vsync;
  assign href_fall = href_q & ~d_href;
  assign pix_line  = d_valid & d_href;

  // Previous delayed href, for line edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) href_q <= 1'b0;
    else        href_q <= d_href;
  end

  // Saturating line count including a line that ends this cycle
  always_comb begin
    line_next = line_cnt;
    if (href_fall && line_cnt != CNT_MAX) line_next = line_cnt + CNT_W'(1);
  end

  // Pixel and line statistics on the delayed stream; href is already low on
  // the falling-edge cycle, so no pixel is added on that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt          <= '0;
      line_cnt         <= '0;
      last_line_pix    <= '0;
      last_frame_lines <= '0;
    end else begin
      if (href_fall) begin
        last_line_pix <= pix_cnt;
        pix_cnt       <= '0;
      end else if (pix_line && pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (fs) begin
        last_frame_lines <= line_next;
        line_cnt         <= '0;
      end else begin
        line_cnt <= line_next;
      end
    end
  end

  // Frame request handshake; a new frame start always wins over an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_req     <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= fs & frame_req & ~frame_req_ack;
      if (fs)                 frame_req <= 1'b1;
      else if (frame_req_ack) frame_req <= 1'b0;
    end
  end

  generate
    if (PACK_MODE == PACK_2PIX) begin : g_pack2
      logic        phase, flush, href_rise, phase_eff;
      logic [15:0] held;

      assign href_rise = d_href & ~href_q;
      // A line's first pixel may coincide with href rising: treat it as even
      assign phase_eff = phase & ~href_rise;

      // Pair pixels within a line; a dangling even pixel is flushed after href falls
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase <= 1'b0;
          flush <= 1'b0;
          held  <= '0;
        end else begin
          flush <= href_fall & phase;
          if (href_fall) begin
            phase <= 1'b0;
          end else if (pix_line) begin
            phase <= ~phase_eff;
            if (!phase_eff) held <= d_data;
          end else if (href_rise) begin
            phase <= 1'b0;
          end
        end
      end

      assign out_en   = (pix_line & phase_eff) | flush;
      assign out_data = flush ? {16'h0000, held} : {d_data, held};
    end else begin : g_rgb888
      assign out_en   = d_valid;
      assign out_data = {rgb565_to_888(d_data), 8'h00};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cam_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_stream_packer
//  Purpose  : Scoreboard bench for cam_stream_packer. One instance per output
//             format shares the same stimulus; a reference model predicts
//             output words (value and cycle), handshake and statistics.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cam_stream_packer;

  localparam int DLY   = 2;
  localparam int CNT_W = 12;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vsync = 1'b0, in_href = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        frame_req_ack = 1'b0;

  logic             en0, en1, req0, req1, ovr0, ovr1;
  logic [31:0]      data0, data1;
  logic [CNT_W-1:0] lpix0, lpix1, flin0, flin1;

  cam_stream_packer #(.DLY(DLY), .PACK_MODE(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
    .in_valid(in_valid), .in_data(in_data),
`ifdef CAM_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .out_en(en0), .out_data(data0), .frame_req(req0), .frame_req_ack(frame_req_ack),
    .last_line_pix(lpix0), .last_frame_lines(flin0), .frame_overrun(ovr0));

  cam_stream_packer #(.DLY(DLY), .PACK_MODE(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
    .in_valid(in_valid), .in_data(in_data),
`ifdef CAM_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .out_en(en1), .out_data(data1), .frame_req(req1), .frame_req_ack(frame_req_ack),
    .last_line_pix(lpix1), .last_frame_lines(flin1), .frame_overrun(ovr1));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int unsigned due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        ack_rand = 1'b0, ack_force = 1'b0;
  logic        lit0 = 1'b0, lit1 = 1'b0;
  logic        m_prev_vs = 1'b0, m_prev_hr = 1'b0, m_has_even = 1'b0;
  logic [15:0] m_even = '0;
  int          m_line_pix = 0, m_line_cnt = 0, m_last_line_pix = 0, m_last_frame_lines = 0;
  logic        exp_req = 1'b0, exp_ovr = 1'b0, vs_prev = 1'b0, fs_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] model_rgb(input logic [15:0] d);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(d) / 2048;
    g6 = (int'(d) / 32) % 64;
    b5 = int'(d) % 32;
    r8 = r5 * 8 + (r5 % 2) * 7;
    g8 = g6 * 4 + (g6 % 2) * 3;
    b8 = b5 * 8 + (b5 % 2) * 7;
    return 32'(r8 * 16777216 + g8 * 65536 + b8 * 256);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Apply one cycle of stimulus and advance the reference model
  task automatic apply(input logic vs, input logic hr, input logic vl, input logic [15:0] d);
    in_vsync = vs; in_href = hr; in_valid = vl; in_data = d;
    frame_req_ack = ack_rand ? ($urandom_range(0, 7) == 0) : ack_force;
    if (vl && !lit0) q0.push_back('{model_rgb(d), cyc + DLY});
    if (vl && hr) begin
      if (!m_has_even) begin
        m_even = d; m_has_even = 1'b1;
      end else begin
        if (!lit1) q1.push_back('{{d, m_even}, cyc + DLY});
        m_has_even = 1'b0;
      end
      m_line_pix = sat_inc(m_line_pix);
    end
    if (m_prev_hr && !hr) begin
      if (m_has_even && !lit1) q1.push_back('{{16'h0000, m_even}, cyc + DLY + 1});
      m_has_even      = 1'b0;
      m_last_line_pix = m_line_pix;
      m_line_pix      = 0;
      m_line_cnt      = sat_inc(m_line_cnt);
    end
    if (m_prev_vs && !vs) begin
      m_last_frame_lines = m_line_cnt;
      m_line_cnt         = 0;
    end
    m_prev_vs = vs; m_prev_hr = hr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic vsync_pulse(input int hi_len, input logic ack_at_fs);
    for (int i = 0; i < hi_len; i++) apply(1'b1, 1'b0, 1'b0, 16'h0000);
    ack_force = ack_at_fs;
    apply(1'b0, 1'b0, 1'b0, 16'h0000);
    ack_force = 1'b0;
  endtask

  task automatic send_line(input int len, input bit full);
    for (int i = 0; i < len; i++)
      apply(1'b0, 1'b1, full ? 1'b1 : ($urandom_range(0, 3) != 0), 16'($urandom()));
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_lpix0"}, 32'(lpix0), 32'(m_last_line_pix));
    chk({tag, "_lpix1"}, 32'(lpix1), 32'(m_last_line_pix));
    chk({tag, "_flin0"}, 32'(flin0), 32'(m_last_frame_lines));
    chk({tag, "_flin1"}, 32'(flin1), 32'(m_last_frame_lines));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en0"},   32'(en0),   0); chk({tag, "_en1"},   32'(en1),   0);
    chk({tag, "_data0"}, data0,      0); chk({tag, "_data1"}, data1,      0);
    chk({tag, "_req0"},  32'(req0),  0); chk({tag, "_req1"},  32'(req1),  0);
    chk({tag, "_ovr0"},  32'(ovr0),  0); chk({tag, "_ovr1"},  32'(ovr1),  0);
    chk({tag, "_lpix0"}, 32'(lpix0), 0); chk({tag, "_lpix1"}, 32'(lpix1), 0);
    chk({tag, "_flin0"}, 32'(flin0), 0); chk({tag, "_flin1"}, 32'(flin1), 0);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    m_prev_vs = 1'b0; m_prev_hr = 1'b0; m_has_even = 1'b0; m_even = '0;
    m_line_pix = 0; m_line_cnt = 0; m_last_line_pix = 0; m_last_frame_lines = 0;
  endtask

  // Monitor: pops scoreboard entries on out_en and tracks the handshake model
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req = 1'b0; exp_ovr = 1'b0; vs_prev = 1'b0;
    end else begin
      while (q0.size() > 0 && q0[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL stream0_missing actual=none expected=%0h due %0d", q0[0].data, q0[0].due);
        void'(q0.pop_front());
      end
      if (en0) begin
        checks++;
        if (q0.size() == 0 || q0[0].due != cyc) begin
          errors++;
          $display("FAIL stream0_unexpected actual=%0h expected=no word (cycle %0d)", data0, cyc);
        end else begin
          e = q0.pop_front();
          if (data0 !== e.data) begin
            errors++;
            $display("FAIL stream0_data actual=%0h expected=%0h (cycle %0d)", data0, e.data, cyc);
          end
        end
      end
      while (q1.size() > 0 && q1[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL stream1_missing actual=none expected=%0h due %0d", q1[0].data, q1[0].due);
        void'(q1.pop_front());
      end
      if (en1) begin
        checks++;
        if (q1.size() == 0 || q1[0].due != cyc) begin
          errors++;
          $display("FAIL stream1_unexpected actual=%0h expected=no word (cycle %0d)", data1, cyc);
        end else begin
          e = q1.pop_front();
          if (data1 !== e.data) begin
            errors++;
            $display("FAIL stream1_data actual=%0h expected=%0h (cycle %0d)", data1, e.data, cyc);
          end
        end
      end
      chk("frame_req0", 32'(req0), 32'(exp_req));
      chk("frame_req1", 32'(req1), 32'(exp_req));
      chk("overrun0",   32'(ovr0), 32'(exp_ovr));
      chk("overrun1",   32'(ovr1), 32'(exp_ovr));
      fs_now  = vs_prev & ~in_vsync;
      exp_ovr = fs_now & exp_req & ~frame_req_ack;
      exp_req = fs_now ? 1'b1 : (frame_req_ack ? 1'b0 : exp_req);
      vs_prev = in_vsync;
    end
  end

  // Stimulus
  initial begin
    int t0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Handshake: request after fs, cleared the cycle after a late ack
    vsync_pulse(3, 1'b0);
    chk("req_set", 32'(req0), 1);
    idle(9);
    ack_force = 1'b1; idle(1); ack_force = 1'b0;
    chk("req_clr", 32'(req0), 0);
    idle(2);

    // Overrun while pending, then fs coincident with ack
    vsync_pulse(3, 1'b0);
    idle(4);
    vsync_pulse(3, 1'b0);
    chk("overrun_pulse", 32'(ovr1), 1);
    chk("overrun_req",   32'(req1), 1);
    idle(1);
    vsync_pulse(3, 1'b1);
    chk("fs_ack_req", 32'(req0), 1);
    chk("fs_ack_ovr", 32'(ovr0), 0);
    ack_force = 1'b1; idle(1); ack_force = 1'b0;
    idle(2);

    // Directed RGB888 words with exact latency
    lit0 = 1'b1;
    t0 = cyc;
    q0.push_back('{32'hFF000000, t0 + DLY});
    q0.push_back('{32'h00FF0000, t0 + 1 + DLY});
    apply(1'b0, 1'b1, 1'b1, 16'hF800);
    apply(1'b0, 1'b1, 1'b1, 16'h07E0);
    lit0 = 1'b0;
    idle(3);

    // Directed two-pixel packing with odd-count flush
    lit1 = 1'b1;
    t0 = cyc;
    q1.push_back('{32'h00020001, t0 + 1 + DLY});
    q1.push_back('{32'h00040003, t0 + 3 + DLY});
    q1.push_back('{32'h00000005, t0 + 5 + DLY + 1});
    for (int i = 1; i <= 5; i++) apply(1'b0, 1'b1, 1'b1, 16'(i));
    idle(DLY + 4);
    lit1 = 1'b0;
    chk("line5_pix0", 32'(lpix0), 5);
    chk("line5_pix1", 32'(lpix1), 5);

    // Randomised frames with random acks
    ack_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      vsync_pulse($urandom_range(2, 4), 1'b0);
      idle(DLY + 3);
      check_stats("rand_fs");
      for (int l = 0; l < int'($urandom_range(1, 12)); l++) begin
        send_line($urandom_range(1, 40), 1'b0);
        idle($urandom_range(1, 4));
      end
      idle(DLY + 3);
      check_stats("rand_eol");
    end
    ack_rand = 1'b0;
    ack_force = 1'b1; idle(1); ack_force = 1'b0;

    // Large frame: 480 lines, then fs latches the line count
    vsync_pulse(3, 1'b0);
    for (int l = 0; l < 480; l++) begin
      send_line(4, 1'b1);
      idle(2);
    end
    idle(DLY + 3);
    vsync_pulse(3, 1'b1);
    idle(DLY + 3);
    chk("frame480_0", 32'(flin0), 480);
    chk("frame480_1", 32'(flin1), 480);
    check_stats("frame480");

    // Long line and saturation of the pixel counter
    send_line(640, 1'b1);
    idle(DLY + 4);
    chk("line640", 32'(lpix0), 640);
    send_line(SAT + 5, 1'b1);
    idle(DLY + 4);
    chk("line_sat0", 32'(lpix0), SAT);
    chk("line_sat1", 32'(lpix1), SAT);

    // Reset in the middle of a line
    send_line(11, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    clear_model();
    in_vsync = 1'b0; in_href = 1'b0; in_valid = 1'b0; in_data = '0; frame_req_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    vsync_pulse(3, 1'b0);
    for (int l = 0; l < 3; l++) begin
      send_line($urandom_range(3, 9), 1'b0);
      idle(2);
    end
    idle(DLY + 3);
    vsync_pulse(3, 1'b1);
    idle(DLY + 3);
    chk("post_reset_lines", 32'(flin1), 3);
    check_stats("post_reset");

    idle(20);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus is finite, this only guards against a stalled run
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
